rca_result_packer: RTL and testbench
====================================

RCA_RESULT_PACKER -- requirements
Module: rca_result_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of one adder result lane.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of adder results packed per output word.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port IN_VALID, input, 1 bit: SUM, COUT and IN_LAST are valid this cycle (upstream aligns it to the adder's one-cycle operand register).
REQ-006 The block SHALL have port SUM, input, DATA_WIDTH bits: adder sum lane.
REQ-007 The block SHALL have port COUT, input, 1 bit: adder carry-out for this lane.
REQ-008 The block SHALL have port IN_LAST, input, 1 bit: this lane closes the current word early.
REQ-009 The block SHALL have port IN_READY, output, 1 bit: the block accepts a lane this cycle.
REQ-010 The block SHALL have port OUT_DATA, output, DATA_WIDTH*LANES bits: packed word, lane 0 in the LSBs.
REQ-011 The block SHALL have port OUT_CARRY, output, 1 bit: COUT of the last lane written into the word.
REQ-012 The block SHALL have port OUT_COUNT, output, $clog2(LANES)+1 bits: number of lanes filled (1..LANES).
REQ-013 The block SHALL have port OUT_VALID, output, 1 bit: the output word is valid.
REQ-014 The block SHALL have port OUT_READY, input, 1 bit: downstream accepts the word.

Function
REQ-015 A lane SHALL be accepted only on a cycle where IN_VALID=1 and IN_READY=1.
REQ-016 An accepted SUM SHALL be written to the lane at the current lane index, and the index SHALL then increment.
REQ-017 A word SHALL complete when the accepted lane has index LANES-1 or IN_LAST=1; the index SHALL then wrap to 0.
REQ-018 In a completed word, unfilled lanes SHALL be zero, OUT_COUNT SHALL equal the accepted lanes, and OUT_CARRY SHALL equal the COUT of the final lane.
REQ-019 The FSM SHALL have two states, COLLECT and FULL; IN_READY SHALL be 1 in COLLECT and 0 in FULL.
REQ-020 On completion in COLLECT, if the output is empty or is being drained this cycle (OUT_VALID and OUT_READY), the word SHALL load into the output register and the FSM SHALL stay in COLLECT; otherwise the word SHALL be held and the FSM SHALL go to FULL.
REQ-021 In FULL, when the output drains, the held word SHALL move to the output register and the FSM SHALL return to COLLECT on the next cycle.
REQ-022 Latency SHALL be one cycle: a word completing on edge t SHALL show OUT_VALID=1 after edge t, provided the output is free.
REQ-023 When drain and load happen in the same cycle, OUT_VALID SHALL stay 1 with the new word and no bubble.
REQ-024 While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_CARRY and OUT_COUNT SHALL hold stable.
REQ-025 Sustained throughput SHALL be one lane per cycle with OUT_READY held 1.
REQ-026 IN_LAST on lane index 0 SHALL produce a single-lane word with OUT_COUNT=1.

Reset
REQ-027 While RST_N=0, the block SHALL hold FSM=COLLECT, lane index=0, OUT_VALID=0, OUT_DATA=0, OUT_CARRY=0, OUT_COUNT=0, the holding register cleared, and IN_READY=1 after release.
REQ-028 Reset asserted mid-word or mid-stall SHALL discard partial and held words; no stale word SHALL appear after release.

Structure
REQ-029 A shared package SHALL define the DATA_WIDTH and LANES defaults and the COLLECT/FULL state encoding, for reuse by the adder-stage testbenches.
REQ-030 The block SHALL be a single module; no sub-module is warranted (assembly register, holding register and output register are inline).

Verification
REQ-031 Four accepted lanes 0x11, 0x22, 0x33, 0x44 with COUT 0,0,0,1 and OUT_READY=1 -> next cycle OUT_DATA=0x44332211, OUT_CARRY=1, OUT_COUNT=4, OUT_VALID for one cycle.
REQ-032 Lanes 0xAA, 0xBB with IN_LAST on 0xBB -> OUT_DATA=0x0000BBAA, OUT_COUNT=2; then IN_LAST on the first lane 0x05 -> OUT_DATA=0x00000005, OUT_COUNT=1.
REQ-033 OUT_READY=0 while two words stream -> first word held stable, second word held, IN_READY=0; raise OUT_READY -> the words emerge in order with no loss and IN_READY=1 one cycle later.
REQ-034 Continuous 16 lanes 0x00..0x0F with OUT_READY=1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive 4-cycle boundaries, IN_READY always 1.
REQ-035 RST_N pulsed low after 2 of 4 lanes and during a FULL stall -> OUT_VALID=0 and all outputs 0 immediately; the next word after release starts at lane 0 with no stale data.

Source files
------------

// File: rtl/rca_result_packer_pkg.sv
// rtl/rca_result_packer_pkg.sv - shared defaults and FSM encoding for the adder result packer
package rca_result_packer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // Width of the lane-count field: must represent 1..lanes inclusive.
  function automatic int count_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/rca_result_packer.sv
// rtl/rca_result_packer.sv - packs adder sum lanes into words with a one-deep skid holding register
module rca_result_packer
  import rca_result_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          IN_VALID,
  input  logic [DATA_WIDTH-1:0]         SUM,
  input  logic                          COUT,
  input  logic                          IN_LAST,
  output logic                          IN_READY,
  output logic [DATA_WIDTH*LANES-1:0]   OUT_DATA,
  output logic                          OUT_CARRY,
  output logic [$clog2(LANES):0]        OUT_COUNT,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY
);

  localparam int WORD_W = DATA_WIDTH * LANES;
  localparam int CNT_W  = count_width(LANES);
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  // Assembly register: lanes above the current index are always zero,
  // because it is cleared whenever a word completes.
  logic [IDX_W-1:0]     r_idx;
  logic [WORD_W-1:0]    r_asm_data;

  // Holding register: a completed word that could not enter the output yet.
  logic [WORD_W-1:0]    r_hold_data;
  logic                 r_hold_carry;
  logic [CNT_W-1:0]     r_hold_count;

  // Output register driving the downstream interface.
  logic [WORD_W-1:0]    r_out_data;
  logic                 r_out_carry;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_valid;

  logic [WORD_W-1:0]    w_word;
  logic [CNT_W-1:0]     w_count;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_complete;
  logic                 w_out_free;
  logic                 w_load_new;
  logic                 w_load_hold;
  logic                 w_move_hold;

  assign w_in_ready = (r_state == COLLECT);
  assign w_accept   = IN_VALID && w_in_ready;
  assign w_drain    = r_out_valid && OUT_READY;
  assign w_complete = w_accept && ((r_idx == LAST_IDX) || IN_LAST);
  assign w_out_free = !r_out_valid || w_drain;
  assign w_count    = CNT_W'(r_idx) + CNT_W'(1);

  // Merge the incoming sum into the lane selected by the current index.
  always_comb begin
    w_word = r_asm_data;
    for (int l = 0; l < LANES; l++) begin
      if (r_idx == IDX_W'(l)) begin
        w_word[l*DATA_WIDTH +: DATA_WIDTH] = SUM;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath steering: a completed word goes straight to the
  // output when it is free this cycle, otherwise it parks in the holding register.
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_load_hold = 1'b0;
    w_move_hold = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_complete) begin
          if (w_out_free) begin
            w_load_new = 1'b1;
          end else begin
            w_load_hold = 1'b1;
            w_state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (w_drain) begin
          w_move_hold = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // Lane assembly: advance the index per accepted lane, wrap and clear on completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx      <= '0;
      r_asm_data <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_idx      <= '0;
        r_asm_data <= '0;
      end else begin
        r_idx      <= r_idx + IDX_W'(1);
        r_asm_data <= w_word;
      end
    end
  end

  // Holding register capture when the output is busy at completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold_data  <= '0;
      r_hold_carry <= 1'b0;
      r_hold_count <= '0;
    end else if (w_load_hold) begin
      r_hold_data  <= w_word;
      r_hold_carry <= COUT;
      r_hold_count <= w_count;
    end
  end

  // Output register: load a fresh or held word, or drop valid once drained.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_new) begin
      r_out_data  <= w_word;
      r_out_carry <= COUT;
      r_out_count <= w_count;
      r_out_valid <= 1'b1;
    end else if (w_move_hold) begin
      r_out_data  <= r_hold_data;
      r_out_carry <= r_hold_carry;
      r_out_count <= r_hold_count;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_DATA  = r_out_data;
  assign OUT_CARRY = r_out_carry;
  assign OUT_COUNT = r_out_count;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_rca_result_packer.sv
// tb/tb_rca_result_packer.sv - scoreboard bench for the adder result packer
module tb_rca_result_packer;
  import rca_result_packer_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int L  = DEF_LANES;
  localparam int WW = DW * L;
  localparam int CW = $clog2(L) + 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [DW-1:0] SUM = '0;
  logic          COUT = 1'b0;
  logic          IN_LAST = 1'b0;
  logic          IN_READY;
  logic [WW-1:0] OUT_DATA;
  logic          OUT_CARRY;
  logic [CW-1:0] OUT_COUNT;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          carry;
    logic [CW-1:0] count;
  } word_t;

  word_t sb[$];
  word_t m_word = '0;
  word_t m_exp;
  int    m_idx = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    waited;

  rca_result_packer #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .SUM       (SUM),
    .COUT      (COUT),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CARRY (OUT_CARRY),
    .OUT_COUNT (OUT_COUNT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CLK = ~CLK;

  // Output monitor: a handshake that will complete at the next rising edge pops the scoreboard.
  always @(negedge CLK) begin
    #1;
    if (RST_N && OUT_VALID && OUT_READY) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=%h carry=%0b count=%0d, required no word", OUT_DATA, OUT_CARRY, OUT_COUNT);
      end else begin
        m_exp = sb.pop_front();
        if ({OUT_DATA, OUT_CARRY, OUT_COUNT} !== m_exp) begin
          n_fail++;
          $display("FAIL sb_word: got data=%h carry=%0b count=%0d, required data=%h carry=%0b count=%0d",
                   OUT_DATA, OUT_CARRY, OUT_COUNT, m_exp.data, m_exp.carry, m_exp.count);
        end
      end
    end
  end

  // Drive one lane from a falling edge; returns at the next falling edge after acceptance.
  task automatic send(input logic [DW-1:0] s, input logic c, input logic l, output int w);
    IN_VALID = 1'b1;
    SUM      = s;
    COUT     = c;
    IN_LAST  = l;
    w        = 0;
    while (!IN_READY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!IN_READY) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got IN_READY=0 for %0d cycles, required 1", w);
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    m_word.data[m_idx*DW +: DW] = s;
    m_word.carry = c;
    m_idx++;
    if (m_idx == L || l) begin
      m_word.count = CW'(m_idx);
      sb.push_back(m_word);
      m_word = '0;
      m_idx  = 0;
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic flush_model();
    sb.delete();
    m_word = '0;
    m_idx  = 0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%h carry=%0b count=%0d, required all 0", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", IN_READY);
    end
  endtask

  task automatic test_full_word();
    OUT_READY = 1'b1;
    send(8'h11, 1'b0, 1'b0, waited);
    send(8'h22, 1'b0, 1'b0, waited);
    send(8'h33, 1'b0, 1'b0, waited);
    send(8'h44, 1'b1, 1'b0, waited);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== {1'b1, 32'h44332211, 1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL full_word: got valid=%0b data=%h carry=%0b count=%0d, required 1 44332211 1 4", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    @(negedge CLK);
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL full_word_one_cycle: got OUT_VALID=%0b, required 0", OUT_VALID);
    end
  endtask

  task automatic test_early_last();
    OUT_READY = 1'b1;
    send(8'hAA, 1'b0, 1'b0, waited);
    send(8'hBB, 1'b1, 1'b1, waited);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== {1'b1, 32'h0000BBAA, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL early_last_two: got valid=%0b data=%h carry=%0b count=%0d, required 1 0000bbaa 1 2", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    send(8'h05, 1'b0, 1'b1, waited);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== {1'b1, 32'h00000005, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL early_last_one: got valid=%0b data=%h carry=%0b count=%0d, required 1 00000005 0 1", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_backpressure();
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'(i), 1'b0, waited);
    n_tests++;
    if (IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready_full: got %0b, required 0", IN_READY);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== {1'b1, 32'hA3A2A1A0, 1'b1, 3'd4}) begin
        n_fail++;
        $display("FAIL bp_stable: got valid=%0b data=%h carry=%0b count=%0d, required 1 a3a2a1a0 1 4", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
      end
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if ({IN_READY, OUT_VALID, OUT_DATA} !== {1'b1, 1'b1, 32'hA7A6A5A4}) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%0b valid=%0b data=%h, required 1 1 a7a6a5a4", IN_READY, OUT_VALID, OUT_DATA);
    end
    @(negedge CLK);
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got OUT_VALID=%0b, required 0", OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0, waited);
      n_tests++;
      if (waited != 0 || OUT_VALID !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL stream_lane%0d: got wait=%0d valid=%0b, required wait=0 valid=%0b", i, waited, OUT_VALID, ((i % 4) == 3));
      end
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b1;
    send(8'h91, 1'b0, 1'b0, waited);
    send(8'h92, 1'b1, 1'b0, waited);
    RST_N = 1'b0;
    #1;
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_word: got valid=%0b data=%h carry=%0b count=%0d, required all 0", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    flush_model();
    @(negedge CLK);
    RST_N = 1'b1;
    send(8'hC1, 1'b0, 1'b0, waited);
    send(8'hC2, 1'b0, 1'b0, waited);
    send(8'hC3, 1'b0, 1'b0, waited);
    send(8'hC4, 1'b0, 1'b0, waited);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_COUNT} !== {1'b1, 32'hC4C3C2C1, 3'd4}) begin
      n_fail++;
      $display("FAIL rst_mid_next: got valid=%0b data=%h count=%0d, required 1 c4c3c2c1 4", OUT_VALID, OUT_DATA, OUT_COUNT);
    end
    @(negedge CLK);
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hD0 + 8'(i), 1'b1, 1'b0, waited);
    RST_N = 1'b0;
    #1;
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== '0 || IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_full: got valid=%0b data=%h carry=%0b count=%0d in_ready=%0b, required 0 0 0 0 1", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT, IN_READY);
    end
    flush_model();
    @(negedge CLK);
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    n_tests++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_stale: got OUT_VALID=%0b data=%h, required 0", OUT_VALID, OUT_DATA);
    end
    send(8'hE1, 1'b1, 1'b1, waited);
    n_tests++;
    if ({OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT} !== {1'b1, 32'h000000E1, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL rst_full_next: got valid=%0b data=%h carry=%0b count=%0d, required 1 000000e1 1 1", OUT_VALID, OUT_DATA, OUT_CARRY, OUT_COUNT);
    end
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_full_word();
    test_early_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d words pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
